bicubic_row_ctrl: RTL and testbench

BICUBIC_ROW_CTRL -- requirements
Module: bicubic_row_ctrl

---
 rtl/bicubic_row_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_bicubic_row_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_row_ctrl.sv
// Bicubic row controller: for each output pixel, fetches four edge-clamped
// source taps from ROM, hands them to the bicubic core with the fractional
// position, waits for the result and writes it to the output RAM.
module bicubic_row_ctrl #(
    parameter int IMG_W  = 100,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] row_base,
    input  logic [ADDR_W-1:0] out_base,
    input  logic [8:0]        out_len,
    input  logic [15:0]       start_pos,
    input  logic [15:0]       step,
    output logic              busy,
    output logic              done,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              core_start,
    output logic [7:0]        core_frac,
    output logic [7:0]        core_p0,
    output logic [7:0]        core_p1,
    output logic [7:0]        core_p2,
    output logic [7:0]        core_p3,
    input  logic              core_done,
    input  logic [7:0]        core_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_ISSUE,
        S_WAIT_CORE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_out_base;
    logic [8:0]        r_out_len;
    logic [15:0]       r_step;
    logic [15:0]       r_pos;
    logic [8:0]        r_j;
    logic [1:0]        r_n;
    logic [7:0]        r_tap0;
    logic [7:0]        r_tap1;
    logic [7:0]        r_tap2;
    logic [7:0]        r_tap3;
    logic [7:0]        r_result;

    logic [8:0]        w_j_next;
    logic [9:0]        w_k_raw;
    logic [9:0]        w_k;
    logic [ADDR_W-1:0] w_rom_addr;

    assign w_j_next = r_j + 9'd1;

    // Source index k = i - 1 + n, computed as (i + n) - 1 so the arithmetic
    // stays unsigned; raw value 0 is the only case where k would be negative.
    always_comb begin
        w_k_raw = {2'b00, r_pos[15:8]} + {8'b0, r_n};
        if (w_k_raw == 10'd0) begin
            w_k = '0;
        end else if (w_k_raw > 10'(IMG_W)) begin
            w_k = 10'(IMG_W - 1);
        end else begin
            w_k = w_k_raw - 10'd1;
        end
        w_rom_addr = r_row_base + ADDR_W'(w_k);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (out_len == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:     if (r_n == 2'd3) w_next = S_CAPTURE;
            S_CAPTURE:   w_next = S_ISSUE;
            S_ISSUE:     w_next = S_WAIT_CORE;
            S_WAIT_CORE: if (core_done) w_next = S_WRITE;
            S_WRITE:     w_next = (w_j_next == r_out_len) ? S_DONE : S_FETCH;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Job parameters, position/index counters, tap and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_base <= '0;
            r_out_base <= '0;
            r_out_len  <= '0;
            r_step     <= '0;
            r_pos      <= '0;
            r_j        <= '0;
            r_n        <= '0;
            r_tap0     <= '0;
            r_tap1     <= '0;
            r_tap2     <= '0;
            r_tap3     <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row_base <= row_base;
                        r_out_base <= out_base;
                        r_out_len  <= out_len;
                        r_step     <= step;
                        r_pos      <= start_pos;
                        r_j        <= '0;
                        r_n        <= '0;
                    end
                end
                S_FETCH: begin
                    // Data for read n-1 arrives while read n is issued
                    case (r_n)
                        2'd1:    r_tap0 <= rom_data;
                        2'd2:    r_tap1 <= rom_data;
                        2'd3:    r_tap2 <= rom_data;
                        default: ;
                    endcase
                    r_n <= r_n + 2'd1;
                end
                S_CAPTURE: r_tap3 <= rom_data;
                S_WAIT_CORE: begin
                    if (core_done) begin
                        r_result <= core_result;
                    end
                end
                S_WRITE: begin
                    r_pos <= r_pos + r_step;
                    r_j   <= w_j_next;
                    r_n   <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode; strobes and addresses are gated by state
    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        rom_rd     = 1'b0;
        rom_addr   = '0;
        core_start = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        core_frac  = r_pos[7:0];
        core_p0    = r_tap0;
        core_p1    = r_tap1;
        core_p2    = r_tap2;
        core_p3    = r_tap3;
        case (r_state)
            S_FETCH: begin
                rom_rd   = 1'b1;
                rom_addr = w_rom_addr;
            end
            S_ISSUE: core_start = 1'b1;
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_out_base + ADDR_W'(r_j);
                wr_data = r_result;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bicubic_row_ctrl.sv
// Scoreboard bench for bicubic_row_ctrl: a job-level reference model queues
// the expected ROM reads, core operands, writes and done pulses; a monitor
// pops and compares as the DUT presents them. A ROM model returns a&0xFF and
// a core model answers after a programmable delay.
module tb_bicubic_row_ctrl;

    localparam int IMG_W  = 100;
    localparam int ADDR_W = 14;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] row_base = '0;
    logic [ADDR_W-1:0] out_base = '0;
    logic [8:0]        out_len = '0;
    logic [15:0]       start_pos = '0;
    logic [15:0]       step = '0;
    logic              busy, done, rom_rd, core_start, wr_en;
    logic [ADDR_W-1:0] rom_addr, wr_addr;
    logic [7:0]        rom_data = '0;
    logic [7:0]        core_frac, core_p0, core_p1, core_p2, core_p3, wr_data;
    logic              core_done = 1'b0;
    logic [7:0]        core_result = '0;

    int                exp_rd[$];
    logic [39:0]       exp_core[$];
    logic [ADDR_W+7:0] exp_wr[$];
    logic [7:0]        res_q[$];
    int                exp_done = 0;
    int                n_checks = 0;
    int                n_pass = 0;
    bit                in_wait = 1'b0;
    logic [39:0]       held = '0;
    int                core_delay = 0;
    int                fixed_res = -1;
    int                resp_cnt = 0;
    logic [7:0]        resp_val = '0;

    always #5 clk = ~clk;

    bicubic_row_ctrl #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .row_base(row_base), .out_base(out_base), .out_len(out_len),
        .start_pos(start_pos), .step(step),
        .busy(busy), .done(done),
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .core_start(core_start), .core_frac(core_frac),
        .core_p0(core_p0), .core_p1(core_p1), .core_p2(core_p2), .core_p3(core_p3),
        .core_done(core_done), .core_result(core_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // ROM: registered read, ROM[a] = a & 0xFF
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_addr[7:0];
    end

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [39:0] act);
        n_checks++;
        $display("FAIL %s: got %0h, expected no such event", name, act);
    endtask

    // Core model: raises core_done for one cycle core_delay cycles after core_start
    initial begin
        forever begin
            @(negedge clk);
            core_done = 1'b0;
            if (rst) begin
                resp_cnt = 0;
            end else begin
                if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        core_done   = 1'b1;
                        core_result = resp_val;
                    end
                end
                if (core_start) begin
                    resp_cnt = (core_delay > 0) ? core_delay : int'($urandom_range(1, 6));
                    resp_val = (res_q.size() > 0) ? res_q.pop_front() : 8'h00;
                end
            end
        end
    end

    // Monitor: compares every DUT transaction against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rom_rd) begin
                    if (exp_rd.size() == 0) fail("rom_rd_extra", 40'(rom_addr));
                    else begin
                        int a;
                        a = exp_rd.pop_front();
                        chk("rom_addr", 40'(rom_addr), 40'(a));
                    end
                end
                if (wr_en) begin
                    in_wait = 1'b0;
                    if (exp_wr.size() == 0) fail("wr_en_extra", 40'(wr_addr));
                    else begin
                        logic [ADDR_W+7:0] w;
                        w = exp_wr.pop_front();
                        chk("wr_addr", 40'(wr_addr), 40'(w[ADDR_W+7:8]));
                        chk("wr_data", 40'(wr_data), 40'(w[7:0]));
                    end
                end
                if (in_wait) begin
                    chk("operand_hold", {core_frac, core_p0, core_p1, core_p2, core_p3}, held);
                end
                if (core_start) begin
                    logic [39:0] cur;
                    cur = {core_frac, core_p0, core_p1, core_p2, core_p3};
                    if (exp_core.size() == 0) fail("core_start_extra", cur);
                    else chk("core_operands", cur, exp_core.pop_front());
                    held    = cur;
                    in_wait = 1'b1;
                end
                if (done) begin
                    if (exp_done == 0) fail("done_extra", 40'(done));
                    else exp_done--;
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, 40'(busy), 0);
        chk({tag, "_done"}, 40'(done), 0);
        chk({tag, "_rom_rd"}, 40'(rom_rd), 0);
        chk({tag, "_rom_addr"}, 40'(rom_addr), 0);
        chk({tag, "_core_start"}, 40'(core_start), 0);
        chk({tag, "_core_frac"}, 40'(core_frac), 0);
        chk({tag, "_core_taps"}, {8'h00, core_p0, core_p1, core_p2, core_p3}, 0);
        chk({tag, "_wr_en"}, 40'(wr_en), 0);
        chk({tag, "_wr_addr"}, 40'(wr_addr), 0);
        chk({tag, "_wr_data"}, 40'(wr_data), 0);
    endtask

    // Reference model of one job, then the start pulse; called at a negedge
    task automatic issue_job(input int rb, input int ob, input int len, input int sp, input int st);
        for (int j = 0; j < len; j++) begin
            int pos;
            int i;
            logic [7:0] t[4];
            logic [7:0] r;
            pos = (sp + j * st) & 16'hFFFF;
            i   = pos >> 8;
            for (int n = 0; n < 4; n++) begin
                int k;
                int a;
                k = i - 1 + n;
                if (k < 0) k = 0;
                if (k > IMG_W - 1) k = IMG_W - 1;
                a = (rb + k) & AMASK;
                exp_rd.push_back(a);
                t[n] = 8'(a & 255);
            end
            r = (fixed_res >= 0) ? 8'(fixed_res) : 8'($urandom_range(0, 255));
            res_q.push_back(r);
            exp_core.push_back({8'(pos & 255), t[0], t[1], t[2], t[3]});
            exp_wr.push_back({ADDR_W'((ob + j) & AMASK), r});
        end
        exp_done++;
        row_base  = ADDR_W'(rb);
        out_base  = ADDR_W'(ob);
        out_len   = 9'(len);
        start_pos = 16'(sp);
        step      = 16'(st);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 40'(busy), 1);
        if (len == 0) begin
            chk("empty_done_pulse", 40'(done), 1);
            @(negedge clk);
            chk("empty_idle", 40'(busy), 0);
            chk("empty_done_single", 40'(done), 0);
        end
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (done !== 1'b1 && c < 20000) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", 40'(done), 1);
        chk("rd_drained", 40'(exp_rd.size()), 0);
        chk("core_drained", 40'(exp_core.size()), 0);
        chk("wr_drained", 40'(exp_wr.size()), 0);
        @(negedge clk);
        chk("idle_after_done", 40'(busy), 0);
    endtask

    task automatic wait_in_wait();
        int c;
        c = 0;
        while (!in_wait && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("reach_wait_core", 40'(in_wait), 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Left edge, started on the first cycle out of reset
        issue_job(0, 200, 2, 16'h0000, 16'h0100);
        wait_done();

        // Right edge clamp
        issue_job(1000, 300, 1, 16'h6280, 16'h0100);
        wait_done();

        // Slow core with fixed result, consecutive write addresses
        core_delay = 5;
        fixed_res  = 8'h5A;
        issue_job(50, 4000, 4, 16'h1234, 16'h0080);
        wait_done();
        core_delay = 0;
        fixed_res  = -1;

        // Empty job
        issue_job(10, 20, 0, 16'h0000, 16'h0000);

        // Start while busy must be ignored
        issue_job(500, 600, 2, 16'h0A00, 16'h0180);
        wait_in_wait();
        row_base  = ADDR_W'(5000);
        out_base  = ADDR_W'(7000);
        out_len   = 9'd7;
        start_pos = 16'h4000;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset in WAIT_CORE, then a new job right after reset releases
        core_delay = 6;
        issue_job(700, 800, 3, 16'h2000, 16'h0100);
        wait_in_wait();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("midjob_reset");
        exp_rd.delete();
        exp_core.delete();
        exp_wr.delete();
        res_q.delete();
        exp_done = 0;
        in_wait  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        core_delay = 0;
        issue_job(900, 1200, 2, 16'h0380, 16'h0040);
        wait_done();

        // Randomized jobs
        for (int r = 0; r < 10; r++) begin
            issue_job(int'($urandom & AMASK), int'($urandom & AMASK),
                      int'($urandom_range(1, 8)), int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 65535)));
            wait_done();
        end

        // Full-length job with position wrap
        issue_job(16300, 16380, 256, 16'hF000, 16'h0140);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
